// File: rtl/mem_stage_pipe_pkg.sv
// Shared constants for the memory pipeline stage: size codes, op-bit positions
// and FSM state encoding.
package mem_stage_pipe_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Bit positions inside in_op = {is_load, is_store, unsigned, size[0]}
   localparam int OP_LOAD  = 3;
   localparam int OP_STORE = 2;
   localparam int OP_UNS   = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   function automatic logic bad_align(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         SZ_WORD: return |off;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_pipe_dmem_bytelane.sv
// Byte-enabled synchronous data RAM; read data registers on the issue edge and
// holds until the next read.
module dmem_bytelane #(
   parameter int    DBITS     = 32,
   parameter int    AW        = 10,
   parameter string INIT_FILE = "dmem.mem"
) (
   input  logic                 clk,
   input  logic [AW-1:0]        addr,
   input  logic [DBITS/8-1:0]   we,
   input  logic [DBITS-1:0]     wdata,
   input  logic                 re,
   output logic [DBITS-1:0]     rdata
);

   localparam int NB = DBITS / 8;

   logic [DBITS-1:0] mem [2**AW];

   // NOTE: memory arrays get no reset; clearing them would force a register
   // implementation instead of block RAM, and contents must survive reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_stage_pipe.sv
// Memory stage between AGEX and WB: aligned loads/stores into a local data RAM,
// valid/ready handshakes on both sides and a forwarding port for the result.
module mem_stage_pipe
   import mem_stage_pipe_pkg::*;
#(
   parameter int    DBITS     = 32,
   parameter int    DMEMWORDS = 1024,
   parameter int    RD_LAT    = 1,
   parameter int    META_W    = 64,
   parameter int    REGNOBITS = 5,
   parameter string INIT_FILE = "dmem.mem"
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_op,
   input  logic [1:0]           in_size,
   input  logic [DBITS-1:0]     in_addr,
   input  logic [DBITS-1:0]     in_wdata,
   input  logic [DBITS-1:0]     in_aluout,
   input  logic [REGNOBITS-1:0] in_rd,
   input  logic                 in_wr_reg,
   input  logic [META_W-1:0]    in_meta,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DBITS-1:0]     out_result,
   output logic [REGNOBITS-1:0] out_rd,
   output logic                 out_wr_reg,
   output logic [META_W-1:0]    out_meta,
   output logic                 out_misalign,
   output logic                 fwd_valid,
   output logic [REGNOBITS-1:0] fwd_rd,
   output logic [DBITS-1:0]     fwd_val
);

   localparam int         AW        = $clog2(DMEMWORDS);
   localparam int         NB        = DBITS / 8;
   localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

   state_t           state, state_nxt;
   logic             accept, ld_go;
   logic             is_load, is_store, is_uns, misalign, out_of_range;
   logic             unused_size0;
   logic [1:0]       off;
   logic [AW-1:0]    widx;
   logic [DBITS-1:0] addr_hi;
   logic [NB-1:0]    be, mem_we;
   logic [DBITS-1:0] wdata_rep, rdata, load_ext;
   logic [15:0]      lane;
   logic [1:0]       wait_cnt, ld_size, ld_off;
   logic             ld_uns;

   assign is_load      = in_op[OP_LOAD];
   assign is_store     = in_op[OP_STORE];
   assign is_uns       = in_op[OP_UNS];
   // The size LSB is also carried in in_size, which is the copy decoded here.
   assign unused_size0 = in_op[0];
   assign off          = in_addr[1:0];
   assign widx         = in_addr[AW+1:2];
   assign addr_hi      = in_addr >> (AW + 2);
   assign out_of_range = |addr_hi;
   assign misalign     = (is_load | is_store) & (bad_align(in_size, off) | out_of_range);

   // NOTE: every signal driven in always_comb gets a default first, so no
   // path through the case leaves it unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         ST_IDLE: in_ready = 1'b1;
         ST_HOLD: in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
      accept = in_valid & in_ready;
      ld_go  = accept & is_load & ~misalign;
      case (state)
         ST_RD_WAIT: if (wait_cnt == 2'd0) state_nxt = ST_HOLD;
         default: begin
            if (accept)                             state_nxt = ld_go ? ST_RD_WAIT : ST_HOLD;
            else if (state == ST_HOLD && out_ready) state_nxt = ST_IDLE;
         end
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      be        = '0;
      wdata_rep = in_wdata;
      case (in_size)
         SZ_BYTE: begin
            be        = NB'(1) << off;
            wdata_rep = {NB{in_wdata[7:0]}};
         end
         SZ_HALF: begin
            be        = NB'(3) << {off[1], 1'b0};
            wdata_rep = {(NB/2){in_wdata[15:0]}};
         end
         default: be = '1;
      endcase
   end

   assign mem_we = (accept & is_store & ~misalign) ? be : '0;

   dmem_bytelane #(
      .DBITS     (DBITS),
      .AW        (AW),
      .INIT_FILE (INIT_FILE)
   ) u_dmem (
      .clk   (clk),
      .addr  (widx),
      .we    (mem_we),
      .wdata (wdata_rep),
      .re    (ld_go),
      .rdata (rdata)
   );

   assign lane = 16'(rdata >> {ld_off, 3'b000});

   always_comb begin
      load_ext = rdata;
      case (ld_size)
         SZ_BYTE: load_ext = ld_uns ? {{(DBITS-8){1'b0}}, lane[7:0]}
                                    : {{(DBITS-8){lane[7]}}, lane[7:0]};
         SZ_HALF: load_ext = ld_uns ? {{(DBITS-16){1'b0}}, lane}
                                    : {{(DBITS-16){lane[15]}}, lane};
         default: load_ext = rdata;
      endcase
   end

   // Sideband fields register at acceptance; a load's result lands when the
   // wait counter expires, and out_valid only rises at that point.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid    <= 1'b0;
         out_result   <= '0;
         out_rd       <= '0;
         out_wr_reg   <= 1'b0;
         out_meta     <= '0;
         out_misalign <= 1'b0;
         wait_cnt     <= 2'd0;
         ld_size      <= SZ_WORD;
         ld_off       <= 2'd0;
         ld_uns       <= 1'b0;
      end else if (accept) begin
         out_valid    <= ~ld_go;
         out_result   <= in_aluout;
         out_rd       <= in_rd;
         out_wr_reg   <= in_wr_reg & ~is_store & ~misalign;
         out_meta     <= in_meta;
         out_misalign <= misalign;
         ld_size      <= in_size;
         ld_off       <= off;
         ld_uns       <= is_uns;
         if (ld_go) wait_cnt <= WAIT_INIT;
      end else if (state == ST_RD_WAIT) begin
         if (wait_cnt == 2'd0) begin
            out_valid  <= 1'b1;
            out_result <= load_ext;
         end else begin
            wait_cnt <= wait_cnt - 2'd1;
         end
      end else if (state == ST_HOLD && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign fwd_valid = out_valid & out_wr_reg;
   assign fwd_rd    = out_rd;
   assign fwd_val   = out_result;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe with RD_LAT=3: stores, extended loads,
// misalignment, back-pressure, throughput and reset in the middle of a load.
module tb_mem_stage_pipe;

   localparam int RD_LAT = 3;

   localparam logic [3:0] OP_ALU = 4'b0000;
   localparam logic [3:0] OP_SW  = 4'b0100;
   localparam logic [3:0] OP_SB  = 4'b0100;
   localparam logic [3:0] OP_LW  = 4'b1000;
   localparam logic [3:0] OP_LB  = 4'b1000;
   localparam logic [3:0] OP_LBU = 4'b1010;
   localparam logic [3:0] OP_LH  = 4'b1001;
   localparam logic [1:0] SZ_B   = 2'b00;
   localparam logic [1:0] SZ_H   = 2'b01;
   localparam logic [1:0] SZ_W   = 2'b10;

   logic        clk, reset;
   logic        in_valid, in_ready, in_wr_reg;
   logic [3:0]  in_op;
   logic [1:0]  in_size;
   logic [31:0] in_addr, in_wdata, in_aluout;
   logic [4:0]  in_rd;
   logic [63:0] in_meta;
   logic        out_valid, out_ready, out_wr_reg, out_misalign, fwd_valid;
   logic [31:0] out_result, fwd_val;
   logic [4:0]  out_rd, fwd_rd;
   logic [63:0] out_meta;

   int checks   = 0;
   int failures = 0;

   mem_stage_pipe #(
      .DBITS     (32),
      .DMEMWORDS (1024),
      .RD_LAT    (RD_LAT),
      .META_W    (64),
      .REGNOBITS (5),
      .INIT_FILE ("")
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_size      (in_size),
      .in_addr      (in_addr),
      .in_wdata     (in_wdata),
      .in_aluout    (in_aluout),
      .in_rd        (in_rd),
      .in_wr_reg    (in_wr_reg),
      .in_meta      (in_meta),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_rd       (out_rd),
      .out_wr_reg   (out_wr_reg),
      .out_meta     (out_meta),
      .out_misalign (out_misalign),
      .fwd_valid    (fwd_valid),
      .fwd_rd       (fwd_rd),
      .fwd_val      (fwd_val)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [3:0] op, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] alu, input logic [4:0] rd,
                         input logic wr, input logic [63:0] meta);
      in_op     = op;
      in_size   = size;
      in_addr   = addr;
      in_wdata  = wdata;
      in_aluout = alu;
      in_rd     = rd;
      in_wr_reg = wr;
      in_meta   = meta;
   endtask

   task automatic send(input logic [3:0] op, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] alu, input logic [4:0] rd,
                       input logic wr, input logic [63:0] meta);
      set_in(op, size, addr, wdata, alu, rd, wr, meta);
      in_valid = 1'b1;
      #1;
      chk("send_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic store_check(input string tag, input logic [3:0] op, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic mis);
      send(op, size, addr, wdata, addr, 5'd3, 1'b1, 64'h5707E);
      chk({tag, "_valid"},    out_valid,    1);
      chk({tag, "_wr_reg"},   out_wr_reg,   0);
      chk({tag, "_misalign"}, out_misalign, mis);
      chk({tag, "_fwd"},      fwd_valid,    0);
   endtask

   task automatic load_check(input string tag, input logic [3:0] op, input logic [1:0] size,
                             input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] exp);
      send(op, size, addr, 32'h0, 32'h0, rd, 1'b1, {32'hCAFE0000, addr});
      for (int i = 1; i <= RD_LAT; i++) begin
         chk({tag, "_wait_valid"}, out_valid, 0);
         chk({tag, "_wait_fwd"},   fwd_valid, 0);
         chk({tag, "_wait_ready"}, in_ready,  0);
         tick();
      end
      chk({tag, "_valid"},    out_valid,    1);
      chk({tag, "_result"},   out_result,   exp);
      chk({tag, "_misalign"}, out_misalign, 0);
      chk({tag, "_fwd"},      fwd_valid,    1);
      chk({tag, "_fwd_val"},  fwd_val,      exp);
      chk({tag, "_rd"},       out_rd,       rd);
      chk({tag, "_meta"},     out_meta,     {32'hCAFE0000, addr});
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      set_in(OP_ALU, SZ_W, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 64'h0);

      #2;
      chk("rst_out_valid",  out_valid,    0);
      chk("rst_misalign",   out_misalign, 0);
      chk("rst_wr_reg",     out_wr_reg,   0);
      chk("rst_fwd_valid",  fwd_valid,    0);
      chk("rst_result",     out_result,   0);
      chk("rst_meta",       out_meta,     0);
      chk("rst_in_ready",   in_ready,     1);
      #10 reset = 1'b1;
      tick();

      // Store word then load the same word on the very next cycle.
      store_check("sw10", OP_SW, SZ_W, 32'h10, 32'hDEADBEEF, 1'b0);
      load_check("lw10", OP_LW, SZ_W, 32'h10, 5'd5, 32'hDEADBEEF);

      // Byte store into lane 3, then signed/unsigned byte and half loads.
      store_check("sb13", OP_SB, SZ_B, 32'h13, 32'h12345680, 1'b0);
      load_check("lb13",  OP_LB,  SZ_B, 32'h13, 5'd6, 32'hFFFFFF80);
      load_check("lbu13", OP_LBU, SZ_B, 32'h13, 5'd7, 32'h00000080);
      load_check("lh12",  OP_LH,  SZ_H, 32'h12, 5'd8, 32'hFFFF80AD);
      load_check("lw10b", OP_LW,  SZ_W, 32'h10, 5'd9, 32'h80ADBEEF);

      // Misaligned half load: latency 1, no register write.
      send(OP_LH, SZ_H, 32'h11, 32'h0, 32'h11, 5'd4, 1'b1, 64'h0);
      chk("lh11_valid",    out_valid,    1);
      chk("lh11_misalign", out_misalign, 1);
      chk("lh11_wr_reg",   out_wr_reg,   0);
      chk("lh11_fwd",      fwd_valid,    0);

      // Misaligned and out-of-range stores must leave memory untouched.
      store_check("sw20",    OP_SW, SZ_W, 32'h20,   32'h11223344, 1'b0);
      store_check("sw_oor",  OP_SW, SZ_W, 32'h1020, 32'h00000000, 1'b1);
      store_check("sw_mis",  OP_SW, SZ_W, 32'h22,   32'h00000000, 1'b1);
      load_check("lw20",  OP_LW, SZ_W, 32'h20, 5'd10, 32'h11223344);
      load_check("lw10c", OP_LW, SZ_W, 32'h10, 5'd11, 32'h80ADBEEF);
      tick();
      chk("drain_valid", out_valid, 0);

      // Back-pressure: first ALU result held while the second waits.
      out_ready = 1'b0;
      send(OP_ALU, SZ_W, 32'h0, 32'h0, 32'hA1, 5'd1, 1'b1, 64'hA1);
      set_in(OP_ALU, SZ_W, 32'h0, 32'h0, 32'hA2, 5'd2, 1'b1, 64'hA2);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", in_ready,   0);
         chk("bp_valid",    out_valid,  1);
         chk("bp_result",   out_result, 32'hA1);
         chk("bp_rd",       out_rd,     1);
         chk("bp_meta",     out_meta,   64'hA1);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("bp2_valid",  out_valid,  1);
      chk("bp2_result", out_result, 32'hA2);
      chk("bp2_rd",     out_rd,     2);
      tick();
      chk("bp_drop_valid", out_valid, 0);

      // Eight back-to-back ALU ops: one result per cycle.
      for (int i = 0; i < 8; i++) begin
         set_in(OP_ALU, SZ_W, 32'h0, 32'h0, 32'hC0DE0000 + i * 17, 5'(i + 8), 1'b1, 64'(i));
         in_valid = 1'b1;
         #1;
         chk("b2b_in_ready", in_ready, 1);
         tick();
         chk("b2b_valid",   out_valid,  1);
         chk("b2b_result",  out_result, 32'hC0DE0000 + i * 17);
         chk("b2b_fwd",     fwd_valid,  1);
         chk("b2b_fwd_val", fwd_val,    32'hC0DE0000 + i * 17);
         chk("b2b_fwd_rd",  fwd_rd,     5'(i + 8));
      end
      in_valid = 1'b0;
      tick();
      chk("b2b_drop_valid", out_valid, 0);

      // Reset while a load sits in RD_WAIT.
      send(OP_LW, SZ_W, 32'h10, 32'h0, 32'h0, 5'd12, 1'b1, 64'hBAD);
      tick();
      reset = 1'b0;
      #1;
      chk("rrw_valid",    out_valid,  0);
      chk("rrw_fwd",      fwd_valid,  0);
      chk("rrw_result",   out_result, 0);
      chk("rrw_rd",       out_rd,     0);
      chk("rrw_meta",     out_meta,   0);
      chk("rrw_in_ready", in_ready,   1);
      @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < RD_LAT + 2; i++) begin
         chk("rrw_idle_valid", out_valid, 0);
         chk("rrw_idle_ready", in_ready,  1);
         tick();
      end
      load_check("lw_after_rst", OP_LW, SZ_W, 32'h10, 5'd13, 32'h80ADBEEF);
      send(OP_ALU, SZ_W, 32'h0, 32'h0, 32'h5A5A5A5A, 5'd14, 1'b1, 64'h77);
      chk("alu_after_rst_valid",  out_valid,  1);
      chk("alu_after_rst_result", out_result, 32'h5A5A5A5A);
      chk("alu_after_rst_wr",     out_wr_reg, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
